// File: rtl/router_pkg.sv
// Shared types and helpers for the bi-NoC router.
// Port count default, index width and one-hot decode.
package router_pkg;

    localparam int NUM_PORTS_DEF = 4;
    localparam int MAX_PORTS     = 8;

    typedef logic [2:0] port_idx_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic logic [MAX_PORTS-1:0] onehot_decode(
        input port_idx_t idx
    );
        return MAX_PORTS'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for one switch output.
// Pointer holds the last winner; scan starts one past it.
module rr_arbiter
    import router_pkg::*;
#(
    parameter  int N = NUM_PORTS_DEF,
    localparam int W = clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         upd,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx
);

    logic [W-1:0] ptr_q, ptr_d;

    // Scan from far to near so the nearest requester is assigned last.
    always_comb begin
        int c;
        c       = 0;
        gnt     = '0;
        gnt_idx = '0;
        for (int k = N; k >= 1; k--) begin
            c = int'(ptr_q) + k;
            if (c >= N) c = c - N;
            if (req[c]) begin
                gnt     = '0;
                gnt[c]  = 1'b1;
                gnt_idx = W'(c);
            end
        end
        ptr_d = ptr_q;
        if (upd && |req) ptr_d = gnt_idx;
    end

    // Pointer reset to the last port so port 0 goes first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= W'(N - 1);
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/router_switch_alloc.sv
// Wormhole switch allocator: per-output round-robin
// with packet lock held until the tail flit crosses.
module router_switch_alloc
    import router_pkg::*;
#(
    parameter  int NUM_PORTS = NUM_PORTS_DEF,
    localparam int PORT_W    = clog2(NUM_PORTS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_PORTS-1:0]          req_valid,
    input  logic [NUM_PORTS*PORT_W-1:0]   req_dest,
    input  logic [NUM_PORTS-1:0]          req_tail,
    input  logic [NUM_PORTS-1:0]          out_ready,
    output logic [NUM_PORTS*NUM_PORTS-1:0] grant_onehot,
    output logic [NUM_PORTS*PORT_W-1:0]   out_sel,
    output logic [NUM_PORTS-1:0]          out_busy,
    output logic [NUM_PORTS-1:0]          xfer
);

    localparam int N = NUM_PORTS;
    localparam int W = PORT_W;

    logic [N-1:0] busy_q, busy_d;
    logic [W-1:0] owner_q [N];
    logic [W-1:0] owner_d [N];
    logic [N-1:0] elig    [N];
    logic [N-1:0] arb_gnt [N];
    logic [W-1:0] arb_idx [N];
    logic [N-1:0] owns, win, rel;

    // Which inputs hold a lock, and who may bid for each output.
    always_comb begin
        owns = '0;
        for (int j = 0; j < N; j++)
            if (busy_q[j]) owns[owner_q[j]] = 1'b1;
        for (int j = 0; j < N; j++)
            for (int i = 0; i < N; i++)
                elig[j][i] = req_valid[i] & ~owns[i] &
                             (req_dest[i*W +: W] == W'(j));
    end

    for (genvar j = 0; j < N; j++) begin : g_arb
        rr_arbiter #(.N(N)) u_arb (
            .clk     (clk),
            .rst_n   (rst_n),
            .req     (elig[j]),
            .upd     (~busy_q[j]),
            .gnt     (arb_gnt[j]),
            .gnt_idx (arb_idx[j])
        );
    end

    // Transfer, release and next lock state per output.
    always_comb begin
        xfer = '0;
        rel  = '0;
        win  = '0;
        for (int j = 0; j < N; j++) begin
            if (busy_q[j] && req_valid[owner_q[j]] && out_ready[j]) begin
                xfer[owner_q[j]] = 1'b1;
                rel[j]           = req_tail[owner_q[j]];
            end
            win[j]     = ~busy_q[j] & |arb_gnt[j];
            busy_d[j]  = busy_q[j] ? ~rel[j] : win[j];
            owner_d[j] = win[j] ? arb_idx[j] : owner_q[j];
        end
    end

    // Lock state; reset drops any in-flight packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            for (int j = 0; j < N; j++) owner_q[j] <= '0;
        end else begin
            busy_q <= busy_d;
            for (int j = 0; j < N; j++) owner_q[j] <= owner_d[j];
        end
    end

    // Grant and crossbar select decoded from registered state only.
    always_comb begin
        logic [MAX_PORTS-1:0] oh;
        oh           = '0;
        grant_onehot = '0;
        out_sel      = '0;
        out_busy     = busy_q;
        for (int j = 0; j < N; j++) begin
            if (busy_q[j]) begin
                oh = onehot_decode(port_idx_t'(j));
                grant_onehot[int'(owner_q[j])*N +: N] = oh[N-1:0];
                out_sel[j*W +: W] = owner_q[j];
            end
        end
    end

endmodule

// File: tb/tb_router_switch_alloc.sv
// Directed bench for router_switch_alloc.
// 4-port instance plus a 5-port one for out-of-range dests.
module tb_router_switch_alloc;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  rv, rt, ordy;
    logic [1:0]  d [4];
    logic [7:0]  rd;
    logic [15:0] gnt;
    logic [7:0]  sel;
    logic [3:0]  busy, xf;

    logic [4:0]  rv5, rt5, ordy5;
    logic [2:0]  d5 [5];
    logic [14:0] rd5;
    logic [24:0] gnt5;
    logic [14:0] sel5;
    logic [4:0]  busy5, xf5;

    int tests = 0;
    int errors = 0;

    assign rd  = {d[3], d[2], d[1], d[0]};
    assign rd5 = {d5[4], d5[3], d5[2], d5[1], d5[0]};

    router_switch_alloc #(.NUM_PORTS(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (rv),
        .req_dest     (rd),
        .req_tail     (rt),
        .out_ready    (ordy),
        .grant_onehot (gnt),
        .out_sel      (sel),
        .out_busy     (busy),
        .xfer         (xf)
    );

    router_switch_alloc #(.NUM_PORTS(5)) dut5 (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (rv5),
        .req_dest     (rd5),
        .req_tail     (rt5),
        .out_ready    (ordy5),
        .grant_onehot (gnt5),
        .out_sel      (sel5),
        .out_busy     (busy5),
        .xfer         (xf5)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    task automatic clr_in;
        rv = '0; rt = '0; ordy = '0;
        for (int i = 0; i < 4; i++) d[i] = '0;
        rv5 = '0; rt5 = '0; ordy5 = '0;
        for (int i = 0; i < 5; i++) d5[i] = '0;
    endtask

    task automatic do_reset;
        clr_in;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        clr_in;
        rst_n = 1'b0;
        rv = 4'hF; ordy = 4'hF; rt = 4'hF;
        rv5 = 5'h1F; ordy5 = 5'h1F;
        tick; tick; sample;
        tests++;
        if (busy !== 4'b0) begin errors++;
            $display("FAIL rst_busy got %b exp %b", busy, 4'b0); end
        tests++;
        if (gnt !== 16'h0) begin errors++;
            $display("FAIL rst_gnt got %h exp %h", gnt, 16'h0); end
        tests++;
        if (sel !== 8'h0) begin errors++;
            $display("FAIL rst_sel got %h exp %h", sel, 8'h0); end
        tests++;
        if (xf !== 4'b0) begin errors++;
            $display("FAIL rst_xfer got %b exp %b", xf, 4'b0); end
        tests++;
        if ({busy5, xf5} !== 10'b0) begin errors++;
            $display("FAIL rst_p5 got %b exp %b", {busy5, xf5}, 10'b0); end
    endtask

    task automatic test_single;
        do_reset;
        tick; rv[0] = 1'b1; d[0] = 2'd2; sample;
        tests++;
        if (gnt !== 16'h0) begin errors++;
            $display("FAIL t1_latency got %h exp %h", gnt, 16'h0); end
        tick; sample;
        tests++;
        if (gnt[3:0] !== 4'b0100) begin errors++;
            $display("FAIL t1_gnt0 got %b exp %b", gnt[3:0], 4'b0100); end
        tests++;
        if (busy !== 4'b0100) begin errors++;
            $display("FAIL t1_busy got %b exp %b", busy, 4'b0100); end
        tests++;
        if (sel[5:4] !== 2'd0 || xf !== 4'b0) begin errors++;
            $display("FAIL t1_sel_xf got %h/%b exp 0/0000", sel[5:4], xf); end
        tick; rt[0] = 1'b1; ordy = 4'hF; sample;
        tests++;
        if (xf !== 4'b0001) begin errors++;
            $display("FAIL t1_xfer got %b exp %b", xf, 4'b0001); end
        tick; rv[0] = 1'b0; rt[0] = 1'b0; sample;
        tests++;
        if (busy !== 4'b0 || gnt !== 16'h0) begin errors++;
            $display("FAIL t1_release got %b/%h exp 0/0", busy, gnt); end
    endtask

    task automatic test_round_robin;
        do_reset;
        tick; rv[1] = 1'b1; d[1] = 2'd0; rv[3] = 1'b1; d[3] = 2'd0; sample;
        tick; rt[1] = 1'b1; ordy[0] = 1'b1; sample;
        tests++;
        if (gnt[7:4] !== 4'b0001 || gnt[15:12] !== 4'b0) begin errors++;
            $display("FAIL rr_first got %h exp 0001", gnt); end
        tests++;
        if (sel[1:0] !== 2'd1) begin errors++;
            $display("FAIL rr_sel1 got %0d exp %0d", sel[1:0], 1); end
        tests++;
        if (xf !== 4'b0010) begin errors++;
            $display("FAIL rr_xf1 got %b exp %b", xf, 4'b0010); end
        tick; rv[1] = 1'b0; rt[1] = 1'b0; sample;
        tests++;
        if (busy !== 4'b0) begin errors++;
            $display("FAIL rr_gap got %b exp %b", busy, 4'b0); end
        tick; rv[1] = 1'b1; d[1] = 2'd0; sample;
        tests++;
        if (gnt[15:12] !== 4'b0001 || gnt[7:4] !== 4'b0) begin errors++;
            $display("FAIL rr_second got %h exp 1000", gnt); end
        tests++;
        if (sel[1:0] !== 2'd3) begin errors++;
            $display("FAIL rr_sel3 got %0d exp %0d", sel[1:0], 3); end
        tick; rt[3] = 1'b1; sample;
        tests++;
        if (xf !== 4'b1000) begin errors++;
            $display("FAIL rr_xf3 got %b exp %b", xf, 4'b1000); end
        tick; rt[3] = 1'b0; sample;
        tests++;
        if (busy !== 4'b0) begin errors++;
            $display("FAIL rr_gap2 got %b exp %b", busy, 4'b0); end
        tick; sample;
        tests++;
        if (gnt[7:4] !== 4'b0001 || sel[1:0] !== 2'd1) begin errors++;
            $display("FAIL rr_third got %h/%0d exp 0001/1",
                     gnt, sel[1:0]); end
    endtask

    task automatic test_stall;
        do_reset;
        tick; rv[2] = 1'b1; d[2] = 2'd1; rt[2] = 1'b1; sample;
        tick; sample;
        tests++;
        if (busy !== 4'b0010 || gnt[11:8] !== 4'b0010) begin errors++;
            $display("FAIL st_lock got %b/%b exp 0010/0010",
                     busy, gnt[11:8]); end
        for (int k = 0; k < 5; k++) begin
            tick;
            if (k == 0) d[2] = 2'd3;
            sample;
            tests++;
            if ({busy, xf} !== 8'b0010_0000) begin errors++;
                $display("FAIL st_hold%0d got %b exp %b",
                         k, {busy, xf}, 8'b0010_0000); end
        end
        tick; ordy = 4'b0010; sample;
        tests++;
        if (xf !== 4'b0100) begin errors++;
            $display("FAIL st_go got %b exp %b", xf, 4'b0100); end
        tick; rv[2] = 1'b0; rt = '0; ordy = '0; sample;
        tests++;
        if (busy !== 4'b0) begin errors++;
            $display("FAIL st_rel got %b exp %b", busy, 4'b0); end
    endtask

    task automatic test_all_ports;
        do_reset;
        tick;
        rv = 4'hF;
        d[0] = 2'd3; d[1] = 2'd2; d[2] = 2'd1; d[3] = 2'd0;
        sample;
        tick; rt[0] = 1'b1; ordy = 4'hF; sample;
        tests++;
        if (busy !== 4'hF) begin errors++;
            $display("FAIL all_busy got %b exp %b", busy, 4'hF); end
        tests++;
        if (gnt !== 16'h1248) begin errors++;
            $display("FAIL all_gnt got %h exp %h", gnt, 16'h1248); end
        tests++;
        if (sel !== 8'h1B) begin errors++;
            $display("FAIL all_sel got %h exp %h", sel, 8'h1B); end
        tests++;
        if (xf !== 4'hF) begin errors++;
            $display("FAIL all_xf got %b exp %b", xf, 4'hF); end
        tick; rv[0] = 1'b0; rt[0] = 1'b0; sample;
        tests++;
        if (busy !== 4'b0111 || gnt !== 16'h1240) begin errors++;
            $display("FAIL all_rel got %b/%h exp 0111/1240", busy, gnt); end
    endtask

    task automatic test_async_reset;
        do_reset;
        tick; rv[2] = 1'b1; d[2] = 2'd3; ordy = 4'b1000; sample;
        tick; sample;
        tests++;
        if (busy !== 4'b1000 || gnt[11:8] !== 4'b1000) begin errors++;
            $display("FAIL ar_lock got %b/%b exp 1000/1000",
                     busy, gnt[11:8]); end
        tests++;
        if (xf !== 4'b0100 || sel[7:6] !== 2'd2) begin errors++;
            $display("FAIL ar_xf got %b/%0d exp 0100/2", xf, sel[7:6]); end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({gnt, sel, busy, xf} !== 32'h0) begin errors++;
            $display("FAIL ar_clear got %h exp %h",
                     {gnt, sel, busy, xf}, 32'h0); end
        rv[2] = 1'b0;
        rv[0] = 1'b1; d[0] = 2'd3;
        rv[3] = 1'b1; d[3] = 2'd3;
        @(negedge clk);
        rst_n = 1'b1;
        tick; sample;
        tests++;
        if (gnt[3:0] !== 4'b1000 || gnt[15:12] !== 4'b0) begin errors++;
            $display("FAIL ar_prio got %h exp 0008", gnt); end
        tests++;
        if (sel[7:6] !== 2'd0) begin errors++;
            $display("FAIL ar_sel got %0d exp %0d", sel[7:6], 0); end
    endtask

    task automatic test_out_of_range;
        do_reset;
        tick;
        rv5[4] = 1'b1; d5[4] = 3'd6;
        rv5[1] = 1'b1; d5[1] = 3'd4;
        sample;
        tick; sample;
        tests++;
        if (busy5 !== 5'b10000) begin errors++;
            $display("FAIL oob_busy got %b exp %b", busy5, 5'b10000); end
        tests++;
        if (gnt5[9:5] !== 5'b10000 || sel5[14:12] !== 3'd1) begin errors++;
            $display("FAIL oob_legal got %b/%0d exp 10000/1",
                     gnt5[9:5], sel5[14:12]); end
        tests++;
        if (gnt5[24:20] !== 5'b0) begin errors++;
            $display("FAIL oob_d6 got %b exp %b", gnt5[24:20], 5'b0); end
        tick; d5[4] = 3'd5; sample;
        tick; sample;
        tests++;
        if (gnt5[24:20] !== 5'b0 || busy5 !== 5'b10000) begin errors++;
            $display("FAIL oob_d5 got %b/%b exp 00000/10000",
                     gnt5[24:20], busy5); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_stall;
        test_all_ports;
        test_async_reset;
        test_out_of_range;
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
